// File: rtl/mem_arb_pkg.sv
// ============================================================================
//  mem_arb_pkg : shared types and constants for the I/D memory arbiter
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } arb_state_t;

    localparam int unsigned TMO_DEFAULT = 255;

endpackage : mem_arb_pkg

`default_nettype wire

// File: rtl/arb_watchdog.sv
// ============================================================================
//  arb_watchdog : counts cycles spent waiting for mready; flags a hung access
//  Revision     : 1.0
// ============================================================================
`default_nettype none

module arb_watchdog #(
    parameter int unsigned TMO = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TMO + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires on the waiting cycle that would bring the count up to TMO.
    assign expired = enable & (count_q == CNT_W'(TMO - 1));

endmodule : arb_watchdog

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  mem_arbiter : shares one single-port memory between fetch (I) and data (D)
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N   = 64,
    parameter int unsigned W   = 32,
    parameter int unsigned TMO = TMO_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ireq,
    input  logic [W-1:0] iadr,
    input  logic         iabort,
    output logic [W-1:0] irdata,
    output logic         ivalid,
    output logic         istall,
    input  logic         dreq,
    input  logic         dwe,
    input  logic [W-1:0] dadr,
    input  logic [N-1:0] dwdata,
    output logic [N-1:0] drdata,
    output logic         dvalid,
    output logic         dstall,
    output logic         mreq,
    output logic         mwe,
    output logic [W-1:0] madr,
    output logic [N-1:0] mwdata,
    input  logic [N-1:0] mrdata,
    input  logic         mready,
    output logic         err
);

    arb_state_t   state_q, state_d;
    logic         mreq_q, mreq_d;
    logic         mwe_q, mwe_d;
    logic [W-1:0] madr_q, madr_d;
    logic [N-1:0] mwdata_q, mwdata_d;
    logic [W-1:0] irdata_q, irdata_d;
    logic [N-1:0] drdata_q, drdata_d;
    logic         ivalid_q, ivalid_d;
    logic         dvalid_q, dvalid_d;
    logic         err_q, err_d;
    logic         lastd_q, lastd_d;
    logic         cancel_q, cancel_d;

    logic         i_elig;
    logic         grant_d;
    logic         grant_i;
    logic         busy;
    logic         wd_expired;

    assign busy    = (state_q != IDLE);
    assign i_elig  = ireq & ~iabort;
    // Under contention the side that did not win last time gets the grant.
    assign grant_d = dreq & (~i_elig | ~lastd_q);
    assign grant_i = i_elig & (~dreq | lastd_q);

    arb_watchdog #(
        .TMO(TMO)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (~busy | mready),
        .enable (busy & ~mready),
        .expired(wd_expired)
    );

    always_comb begin
        state_d  = state_q;
        mreq_d   = mreq_q;
        mwe_d    = mwe_q;
        madr_d   = madr_q;
        mwdata_d = mwdata_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        ivalid_d = 1'b0;
        dvalid_d = 1'b0;
        err_d    = 1'b0;
        lastd_d  = lastd_q;
        cancel_d = cancel_q;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d  = DBUSY;
                    mreq_d   = 1'b1;
                    mwe_d    = dwe;
                    madr_d   = dadr;
                    mwdata_d = dwdata;
                    lastd_d  = 1'b1;
                end else if (grant_i) begin
                    state_d  = IBUSY;
                    mreq_d   = 1'b1;
                    mwe_d    = 1'b0;
                    madr_d   = iadr;
                    lastd_d  = 1'b0;
                    cancel_d = 1'b0;
                end
            end
            IBUSY: begin
                if (iabort) begin
                    cancel_d = 1'b1;
                end
                // A cancelled fetch still finishes its handshake; only the pulse is dropped.
                if (mready) begin
                    irdata_d = mrdata[W-1:0];
                    ivalid_d = ~(cancel_q | iabort);
                    cancel_d = 1'b0;
                    mreq_d   = 1'b0;
                    state_d  = IDLE;
                end else if (wd_expired) begin
                    err_d    = 1'b1;
                    cancel_d = 1'b0;
                    mreq_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            DBUSY: begin
                if (mready) begin
                    drdata_d = mrdata;
                    dvalid_d = 1'b1;
                    mreq_d   = 1'b0;
                    state_d  = IDLE;
                end else if (wd_expired) begin
                    err_d    = 1'b1;
                    mreq_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                mreq_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            mreq_q   <= 1'b0;
            mwe_q    <= 1'b0;
            madr_q   <= '0;
            mwdata_q <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
            ivalid_q <= 1'b0;
            dvalid_q <= 1'b0;
            err_q    <= 1'b0;
            lastd_q  <= 1'b0;
            cancel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mreq_q   <= mreq_d;
            mwe_q    <= mwe_d;
            madr_q   <= madr_d;
            mwdata_q <= mwdata_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
            ivalid_q <= ivalid_d;
            dvalid_q <= dvalid_d;
            err_q    <= err_d;
            lastd_q  <= lastd_d;
            cancel_q <= cancel_d;
        end
    end

    assign mreq   = mreq_q;
    assign mwe    = mwe_q;
    assign madr   = madr_q;
    assign mwdata = mwdata_q;
    assign irdata = irdata_q;
    assign drdata = drdata_q;
    assign ivalid = ivalid_q;
    assign dvalid = dvalid_q;
    assign err    = err_q;
    assign istall = ireq & ~ivalid_q;
    assign dstall = dreq & ~dvalid_q;

endmodule : mem_arbiter

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port memory between the pipeline's instruction-fetch side (I) and data-access side (D).
- Latches the granted request and drives the memory handshake until completion; returns read data with a one-cycle valid pulse.
- Generates stall signals for the hazard logic and aborts hung accesses with a watchdog.
- Sits between the datapath's fetch/memory stages and the unified memory model.

Parameters:
N, 64, data-side data width
W, 32, address width and instruction width
TMO, 255, watchdog limit in cycles waiting for mready (1..65535)

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-low reset (asserted when 0)
ireq  in  1  fetch request, held until ivalid or iabort
iadr  in  W  fetch address
iabort  in  1  cancel pending/in-flight fetch (branch/jump flush)
irdata  out  W  fetched instruction (registered)
ivalid  out  1  one-cycle pulse, irdata valid
istall  out  1  ireq & ~ivalid (combinational)
dreq  in  1  data request, held until dvalid
dwe  in  1  1 = store, 0 = load
dadr  in  W  data address
dwdata  in  N  store data
drdata  out  N  load data (registered)
dvalid  out  1  one-cycle pulse, load/store complete
dstall  out  1  dreq & ~dvalid (combinational)
mreq  out  1  memory request, held until mready
mwe  out  1  memory write enable
madr  out  W  memory address
mwdata  out  N  memory write data
mrdata  in  N  memory read data, valid with mready
mready  in  1  memory completion, one-cycle pulse
err  out  1  one-cycle pulse on watchdog timeout

Behaviour:
- Reset (reset=0, async): state IDLE; mreq, mwe, ivalid, dvalid, err = 0; madr, mwdata, irdata, drdata = 0; watchdog = 0; lastD = 0.
- States: IDLE, IBUSY, DBUSY.
- IDLE arbitration on posedge:
  - dreq only -> DBUSY.
  - ireq & ~iabort only -> IBUSY.
  - Both pending: D wins unless lastD=1, then I wins. This alternates under contention; neither side starves.
- On grant: latch address (and dwe/dwdata for D) into madr/mwe/mwdata. Set mreq=1 and watchdog=0.
- lastD <= 1 on a D grant, 0 on an I grant.
- mwe=0 for I grants.
- In BUSY: mreq stays 1 and latched fields stay stable regardless of requester inputs. Watchdog increments each cycle mready=0.
- mready=1 in DBUSY:
  - drdata <= mrdata (loads and stores alike).
  - dvalid=1 for the next cycle.
  - mreq <= 0; state -> IDLE.
- mready=1 in IBUSY:
  - irdata <= mrdata[W-1:0].
  - ivalid=1 next cycle unless the fetch was cancelled.
  - mreq <= 0; state -> IDLE.
- Latency: request seen in IDLE at edge k -> mreq high after k. With mready at edge k+L, valid is high in the cycle after k+L. Minimum issue interval is L+1 cycles.
- iabort in IBUSY:
  - Set sticky "cancelled" flag; the memory access runs to completion (no mid-handshake drop).
  - On mready, no ivalid; the flag clears.
- iabort in IDLE: blocks an I grant that cycle.
- Watchdog: when the count reaches TMO with mready still 0, err pulses one cycle, mreq <= 0, and state -> IDLE. No valid pulse is issued. The requester keeps its request and is re-arbitrated normally.
- mready in IDLE: ignored.
- Requester drops req mid-transaction: the transaction completes and valid still pulses.
- Stalls: a side stalls while its request is pending and unserved. A new ireq/dreq in the valid cycle is a new request.
- Same-cycle grant is forbidden in the valid cycle: the FSM passes through IDLE for one cycle after each completion.
- Reset mid-transaction: immediate return to reset values. The outstanding memory access is abandoned; the memory model must tolerate mreq falling.

Decomposition:
- Package mem_arb_pkg: state enum arb_state_t {IDLE, IBUSY, DBUSY}; default TMO constant.
- One sub-module arb_watchdog: clear, enable, TMO parameter; outputs expired. Counter width $clog2(TMO+1).

Test Plan:
- Single load: dreq=1, dwe=0, dadr=0x100, mready at 3rd cycle after mreq with mrdata=0x1122334455667788 -> madr=0x100, mwe=0, dvalid one cycle, drdata=0x1122334455667788, mreq=0 next cycle.
- Contention: ireq and dreq held from reset release, mready after 1 cycle each time -> grant order D, I, D, I. madr alternates dadr/iadr; no ivalid/dvalid overlap.
- Store: dreq=1, dwe=1, dadr=0x20, dwdata=0xDEADBEEFCAFEF00D -> mwe=1, mwdata=0xDEADBEEFCAFEF00D stable until mready; dvalid pulses; dstall=1 until then.
- Abort: IBUSY, iabort pulse before mready, mrdata=0x8C080004 -> mreq held until mready, no ivalid, irdata updated, next ireq served normally.
- Timeout with TMO=4: dreq, mready never asserted -> err pulses after 4 waiting cycles, mreq=0, FSM re-grants D one cycle later.
- Reset mid-IBUSY: reset=0 asynchronously -> mreq, ivalid, err = 0 immediately; after release, idle until the next request.
